load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU request channel and a single-port word-wide data memory.
// Sub-word stores are read-modify-write; build with LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
    parameter int MEM_WORDS = 1000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_dqm,
    input  logic [31:0] mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request; mem_addr follows req_addr
    // LOAD   | memory read of the addressed word
    // RMW_RD | read of the merge base for SB/SH
    // WRITE  | single-cycle memory write
    // RESP   | response held until the CPU takes it
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state_q,  state_d;
    logic        write_q,  write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] base_q,   base_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic        f3_ok;
    logic        range_ok;
    logic        misalign;
    logic        illegal;
    logic [31:0] addr_adj;

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'h0, b};
            F3_HU:   r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] base,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = base;
        case (f3)
            F3_B: r[8*lo +: 8] = wd[7:0];
            F3_H: begin
                if (lo[1]) r[31:16] = wd[15:0];
                else       r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    always_comb begin
        if (req_write) begin
            f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
        end else begin
            f3_ok = !((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111));
        end
        range_ok = {2'b00, req_addr[31:2]} < MEM_WORDS_W;
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        addr_adj = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        illegal = !f3_ok || !range_ok || misalign;
`else
        // Clearing the offending bits of an aligned address is a no-op, so no misalign gating needed.
        if (req_funct3[1:0] == 2'b01) addr_adj[0]   = 1'b0;
        if (req_funct3[1:0] == 2'b10) addr_adj[1:0] = 2'b00;
        illegal = !f3_ok || !range_ok;
`endif
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        base_d    = base_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        mem_dqm   = 2'b10;
        mem_addr  = {2'b00, addr_q[31:2]};

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                mem_addr  = {2'b00, req_addr[31:2]};
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = addr_adj;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = illegal;
                    if (illegal)                 state_d = RESP;
                    else if (!req_write)         state_d = LOAD;
                    else if (req_funct3 == F3_W) state_d = WRITE;
                    else                         state_d = RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = load_extend(funct3_q, addr_q[1:0], mem_rdata);
                state_d = RESP;
            end
            RMW_RD: begin
                base_d  = mem_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = store_merge(funct3_q, addr_q[1:0], base_q, wdata_q);
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            base_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            base_q   <= base_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data memory and a response scoreboard.
module tb_load_store_unit;

    localparam int MW = 1000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_dqm;
    logic [31:0] mem_rdata;

    logic [31:0] mem [MW];
    logic        mem_clr;
    logic        bd_we;
    int          bd_idx;
    logic [31:0] bd_data;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_dqm    (mem_dqm),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MW; i++) mem[i] <= 32'h0;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_we && (mem_addr < MW)) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_addr < MW) ? mem[mem_addr[9:0]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // One full transaction: drive, wait for the response within a bound, compare against the
    // scoreboard, optionally stall rsp_ready, then hand the response back.
    task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_nwe, input logic [31:0] exp_widx,
                          input logic [31:0] exp_wword, input int hold);
        int          cyc;
        int          wecnt;
        logic [31:0] wd_seen;
        logic [31:0] wi_seen;
        logic [32:0] e;
        exp_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " idle mem_addr"}, mem_addr, {2'b00, a[31:2]});
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc     = 1;
        wecnt   = 0;
        wd_seen = 32'h0;
        wi_seen = 32'h0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            if (mem_we === 1'b1) begin
                wecnt++;
                wd_seen = mem_wdata;
                wi_seen = mem_addr;
            end
            chk({tag, " dqm"}, 32'(mem_dqm), 32'd2);
            @(posedge clk);
            #1 cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " we count"}, 32'(wecnt), 32'(exp_nwe));
        if (exp_nwe > 0) begin
            chk({tag, " wr index"}, wi_seen, exp_widx);
            chk({tag, " wr data"}, wd_seen, exp_wword);
        end
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
            e = 33'h0;
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, " rsp_rdata"}, rsp_rdata, e[31:0]);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(e[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold rdata"}, rsp_rdata, e[31:0]);
            chk({tag, " hold err"}, 32'(rsp_err), 32'(e[32]));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, " rsp dropped"}, 32'(rsp_valid), 32'd0);
        chk({tag, " back idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        mem_clr    = 1'b1;
        bd_we      = 1'b0;
        bd_idx     = 0;
        bd_data    = 32'h0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err",   32'(rsp_err), 32'd0);
        chk("reset mem_we",    32'(mem_we), 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset mem_dqm",   32'(mem_dqm), 32'd2);
        @(negedge clk);
        rst     = 1'b0;
        mem_clr = 1'b0;

        access("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'd4, 32'hDEADBEEF, 0);
        access("LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'd0, 32'h0, 0);

        poke(4, 32'h11223344);
        access("SB 0x12",  1'b1, 3'b000, 32'h12, 32'h000000AA, 32'h0, 1'b0, 3, 1, 32'd4, 32'h11AA3344, 0);
        access("LB 0x12",  1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 32'd0, 32'h0, 0);
        access("LBU 0x12", 1'b0, 3'b100, 32'h12, 32'h0, 32'h000000AA, 1'b0, 2, 0, 32'd0, 32'h0, 0);
        access("LB 0x11",  1'b0, 3'b000, 32'h11, 32'h0, 32'h00000033, 1'b0, 2, 0, 32'd0, 32'h0, 0);

        poke(5, 32'h80017FFF);
        access("LH 0x16",  1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 1'b0, 2, 0, 32'd0, 32'h0, 0);
        access("LHU 0x14", 1'b0, 3'b101, 32'h14, 32'h0, 32'h00007FFF, 1'b0, 2, 0, 32'd0, 32'h0, 0);
        access("LH 0x14",  1'b0, 3'b001, 32'h14, 32'h0, 32'h00007FFF, 1'b0, 2, 0, 32'd0, 32'h0, 0);
        access("SH 0x16",  1'b1, 3'b001, 32'h16, 32'hCAFE1234, 32'h0, 1'b0, 3, 1, 32'd5, 32'h12347FFF, 0);
        access("LW 0x14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h12347FFF, 1'b0, 2, 0, 32'd0, 32'h0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        access("LW 0x13 trap", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 32'd0, 32'h0, 0);
        access("SH 0x11 trap", 1'b1, 3'b001, 32'h11, 32'h5678, 32'h0, 1'b1, 1, 0, 32'd0, 32'h0, 0);
        access("LW 0x10 after", 1'b0, 3'b010, 32'h10, 32'h0, 32'h11AA3344, 1'b0, 2, 0, 32'd0, 32'h0, 0);
`else
        access("LW 0x13 align", 1'b0, 3'b010, 32'h13, 32'h0, 32'h11AA3344, 1'b0, 2, 0, 32'd0, 32'h0, 0);
        access("SH 0x11 align", 1'b1, 3'b001, 32'h11, 32'h5678, 32'h0, 1'b0, 3, 1, 32'd4, 32'h11AA5678, 0);
        access("LW 0x10 after", 1'b0, 3'b010, 32'h10, 32'h0, 32'h11AA5678, 1'b0, 2, 0, 32'd0, 32'h0, 0);
`endif

        access("load f3 011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 32'd0, 32'h0, 5);
        access("SW range",     1'b1, 3'b010, 32'(4 * MW), 32'h01020304, 32'h0, 1'b1, 1, 0, 32'd0, 32'h0, 5);
        access("store f3 011", 1'b1, 3'b011, 32'h10, 32'h01020304, 32'h0, 1'b1, 1, 0, 32'd0, 32'h0, 0);
        access("LW last word", 1'b0, 3'b010, 32'(4 * (MW - 1)), 32'h0, 32'h0, 1'b0, 2, 0, 32'd0, 32'h0, 0);

        // Abort an SB while its write is on the memory port.
        poke(8, 32'hCAFEF00D);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort in WRITE", 32'(mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort mem_we",    32'(mem_we), 32'd0);
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort no rsp", 32'(rsp_valid), 32'd0);
            chk("abort idle",   32'(req_ready), 32'd1);
        end
        chk("abort word kept", mem[8], 32'hCAFEF00D);
        access("LW 0x20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 32'd0, 32'h0, 0);

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
